// File: rtl/mem_pkg.sv
// Shared memory-port types: op encoding and the system-level request bundle.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_LD  = 2'd0,
    MEM_ST  = 2'd1,
    MEM_AMO = 2'd2,
    MEM_RSV = 2'd3
  } mem_op_t;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 64;

  typedef struct packed {
    mem_op_t                   op;
    logic [DEF_DATA_W/8-1:0]   mask;
    logic [DEF_ADDR_W-1:0]     addr;
    logic [DEF_DATA_W-1:0]     data;
  } mem_req_t;

  // Channel-index width; a single channel still needs one bit to carry a tag.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response/memory bundle between request sources and the arbiter.
interface mem_port_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) ();
  import mem_pkg::*;

  logic [NUM_CH-1:0]                req_valid;
  logic [NUM_CH-1:0]                req_ready;
  logic [NUM_CH-1:0][1:0]           req_op;
  logic [NUM_CH-1:0][DATA_W/8-1:0]  req_mask;
  logic [NUM_CH-1:0][ADDR_W-1:0]    req_addr;
  logic [NUM_CH-1:0][DATA_W-1:0]    req_data;
  logic [NUM_CH-1:0]                resp_valid;
  logic [DATA_W-1:0]                resp_data;
  logic                             mem_en;
  mem_op_t                          mem_op;
  logic [DATA_W/8-1:0]              mem_mask;
  logic [ADDR_W-1:0]                mem_addr;
  logic [DATA_W-1:0]                mem_data;
  logic [DATA_W-1:0]                mem_resp;

  modport slave (
    input  req_valid, req_op, req_mask, req_addr, req_data, mem_resp,
    output req_ready, resp_valid, resp_data, mem_en, mem_op, mem_mask, mem_addr, mem_data
  );

  modport master (
    output req_valid, req_op, req_mask, req_addr, req_data, mem_resp,
    input  req_ready, resp_valid, resp_data, mem_en, mem_op, mem_mask, mem_addr, mem_data
  );

endinterface

// File: rtl/mem_port_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr, modulo N.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  int unsigned   j;

  // Scan from the far end back to rr_ptr so the closest requester wins last.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    j         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % N;
      if (req_i[j]) begin
        gnt_o     = '0;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && |req_i)
      ptr_d = (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel front end onto a single registered memory port, with a tag
// pipeline that routes each response back to its issuing channel.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int MEM_LAT = 1
) (
  input logic               CLK,
  input logic               RESET,
  mem_port_arbiter_if.slave bus
);

  localparam int IW = idx_w(NUM_CH);
  localparam int MW = DATA_W / 8;

  typedef struct packed {
    mem_op_t           op;
    logic [MW-1:0]     mask;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic [NUM_CH-1:0]              req_v, gnt;
  logic [IW-1:0]                  gnt_idx;
  logic                           accept;
  req_t                           sel, issue_q;
  logic                           mem_en_q;
  logic [IW-1:0]                  issue_ch_q;
  logic [MEM_LAT-1:0]             vld_pipe_q;
  logic [MEM_LAT-1:0][IW-1:0]     ch_pipe_q;
  logic [NUM_CH-1:0]              resp_valid;

  // Masking requests during reset keeps both grants and rr_ptr quiet.
  assign req_v = RESET ? '0 : bus.req_valid;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .req_i    (req_v),
    .advance_i(accept),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx)
  );

  assign accept        = |gnt;
  assign bus.req_ready = gnt;

  always_comb begin
    sel.op   = mem_op_t'(bus.req_op[gnt_idx]);
    sel.mask = bus.req_mask[gnt_idx];
    sel.addr = bus.req_addr[gnt_idx];
    sel.data = bus.req_data[gnt_idx];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_en_q   <= 1'b0;
      issue_q    <= '0;
      issue_ch_q <= '0;
    end else begin
      mem_en_q <= accept;
      if (accept) begin
        issue_q    <= sel;
        issue_ch_q <= gnt_idx;
      end
    end
  end

  assign bus.mem_en   = mem_en_q;
  assign bus.mem_op   = issue_q.op;
  assign bus.mem_mask = issue_q.mask;
  assign bus.mem_addr = issue_q.addr;
  assign bus.mem_data = issue_q.data;

  // Stage 0 tracks the issue register, so the last stage lines up with mem_resp.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_pipe_q <= '0;
      ch_pipe_q  <= '0;
    end else begin
      vld_pipe_q[0] <= mem_en_q;
      ch_pipe_q[0]  <= issue_ch_q;
      for (int s = 1; s < MEM_LAT; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        ch_pipe_q[s]  <= ch_pipe_q[s-1];
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    if (vld_pipe_q[MEM_LAT-1] && !RESET)
      resp_valid[ch_pipe_q[MEM_LAT-1]] = 1'b1;
  end

  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = bus.mem_resp;

endmodule
